// File: rtl/pipearch_writeback_burst_if.sv
// CCI-P channel-1 type subset used by the writeback block, and the
// common-read to writeback streaming interface.
package ccip_lite_pkg;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [15:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h8
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic         sop;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         hit_miss;
        logic         format;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;
endpackage

interface internal_interface;
    import ccip_lite_pkg::*;

    logic         rvalid;
    t_ccip_clData rdata;
    logic         almostfull;

    modport master          (output rvalid, output rdata, input  almostfull);
    modport slave           (input  rvalid, input  rdata, output almostfull);
    modport from_commonread (input  rvalid, input  rdata, output almostfull);
endinterface

// File: rtl/pipearch_writeback_burst.sv
// Streams staged lines to host memory over CCI-P c1 using aligned 4-line
// bursts where possible, bounded by an outstanding-write credit limit.
module pipearch_writeback_burst
    import ccip_lite_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int ALMFULL_SLACK = 4,
    parameter int MAX_OUTSTND   = 64,
    parameter bit BURST_EN      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        op_start,
    output logic                        op_done,
    output logic                        op_busy,
    input  logic [4:0][31:0]            regs,
    input  t_ccip_clAddr                in_addr,
    input  t_ccip_clAddr                out_addr,
    internal_interface.from_commonread  outfrom_read,
    input  logic                        c1TxAlmFull,
    input  t_if_ccip_c1_Rx              cp2af_sRx_c1,
    output t_if_ccip_c1_Tx              af2cp_sTx_c1
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} t_state;

    t_state state, state_nxt;

    t_ccip_clData fifo_mem [FIFO_DEPTH];
    logic [PW:0]  wr_ptr, rd_ptr, fifo_count;
    logic         fifo_full, fifo_push;

    logic [31:0]  len, sent, acked;
    logic [31:0]  remaining, outstnd, ack_inc, acked_nxt;
    t_ccip_clAddr addr0, cur_addr, burst_addr;
    logic         in_burst;
    logic [1:0]   beat;
    logic         burst_ok, issue, issue_sop, start_burst;

    t_ccip_c1_ReqMemHdr tx_hdr_p1;
    t_ccip_clData       tx_data_p1;
    logic               vld_p1;

    logic unused_ok;
    assign unused_ok = ^{regs[2:0], cp2af_sRx_c1.hdr.vc_used,
                         cp2af_sRx_c1.hdr.hit_miss, cp2af_sRx_c1.hdr.mdata};

    // Credit covers the whole request up front; burst beats after the first never re-check it.
    function automatic logic credit_ok(input logic [31:0] outst, input logic [2:0] blen);
        return ({1'b0, outst} + {30'd0, blen}) <= 33'(MAX_OUTSTND);
    endfunction

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
    assign fifo_push  = outfrom_read.rvalid && !fifo_full;
    assign outfrom_read.almostfull = (fifo_count >= (PW+1)'(FIFO_DEPTH - ALMFULL_SLACK));

    assign cur_addr  = addr0 + t_ccip_clAddr'(sent);
    assign remaining = len - sent;
    assign outstnd   = sent - acked;
    assign burst_ok  = BURST_EN && (cur_addr[1:0] == 2'b00) && (remaining >= 32'd4)
                       && (fifo_count >= (PW+1)'(4));

    assign op_busy = (state != S_IDLE);

    always_comb begin
        ack_inc = 32'd0;
        if ((state == S_RUN || state == S_DRAIN) && cp2af_sRx_c1.rspValid
            && cp2af_sRx_c1.hdr.resp_type == eRSP_WRLINE) begin
            ack_inc = cp2af_sRx_c1.hdr.format ? 32'(cp2af_sRx_c1.hdr.cl_num) + 32'd1 : 32'd1;
        end
    end

    assign acked_nxt = acked + ack_inc;

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        issue_sop   = 1'b0;
        start_burst = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_start) begin
                    state_nxt = (regs[4] == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_burst) begin
                    issue = !c1TxAlmFull;
                end else if (!c1TxAlmFull) begin
                    if (burst_ok) begin
                        if (credit_ok(outstnd, 3'd4)) begin
                            issue       = 1'b1;
                            issue_sop   = 1'b1;
                            start_burst = 1'b1;
                        end
                    end else if (fifo_count != '0 && credit_ok(outstnd, 3'd1)) begin
                        issue     = 1'b1;
                        issue_sop = 1'b1;
                    end
                end
                if (issue && (sent + 32'd1 == len)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (acked_nxt == len) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= outfrom_read.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len      <= 32'd0;
            sent     <= 32'd0;
            acked    <= 32'd0;
            addr0    <= '0;
            in_burst <= 1'b0;
            beat     <= 2'd0;
            op_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_done <= (state == S_DONE);
            acked   <= acked_nxt;
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
                sent   <= sent + 32'd1;
                if (start_burst) begin
                    in_burst <= 1'b1;
                    beat     <= 2'd1;
                end else if (in_burst) begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        in_burst <= 1'b0;
                    end
                end
            end
            if (state == S_IDLE && op_start) begin
                len      <= regs[4];
                sent     <= 32'd0;
                acked    <= 32'd0;
                in_burst <= 1'b0;
                beat     <= 2'd0;
                addr0    <= (regs[3][31] ? in_addr : out_addr) + t_ccip_clAddr'(regs[3][30:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_burst) begin
            burst_addr <= cur_addr;
        end
    end

    // p1: registered c1 request; only the valid carries reset
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tx_hdr_p1.vc_sel   <= eVC_VA;
            tx_hdr_p1.sop      <= issue_sop;
            tx_hdr_p1.cl_len   <= (start_burst || in_burst) ? eCL_LEN_4 : eCL_LEN_1;
            tx_hdr_p1.req_type <= eREQ_WRLINE_I;
            tx_hdr_p1.address  <= in_burst ? burst_addr : cur_addr;
            tx_hdr_p1.mdata    <= sent[15:0];
            tx_data_p1         <= fifo_mem[rd_ptr[PW-1:0]];
        end
    end

    assign af2cp_sTx_c1.hdr   = tx_hdr_p1;
    assign af2cp_sTx_c1.data  = tx_data_p1;
    assign af2cp_sTx_c1.valid = vld_p1;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(outfrom_read.rvalid && fifo_full));

endmodule

// File: tb/tb_pipearch_writeback_burst.sv
// Scoreboard bench for pipearch_writeback_burst: directed operations push
// expected c1 writes; a monitor pops and compares each presented write.
module tb_pipearch_writeback_burst;
    import ccip_lite_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            op_start;
    logic            op_done;
    logic            op_busy;
    logic [4:0][31:0] regs;
    t_ccip_clAddr    in_addr;
    t_ccip_clAddr    out_addr;
    logic            c1TxAlmFull;
    t_if_ccip_c1_Rx  rx;
    t_if_ccip_c1_Tx  tx;

    internal_interface rd_if();

    pipearch_writeback_burst #(
        .FIFO_DEPTH(16), .ALMFULL_SLACK(4), .MAX_OUTSTND(4), .BURST_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done),
        .op_busy(op_busy), .regs(regs), .in_addr(in_addr), .out_addr(out_addr),
        .outfrom_read(rd_if), .c1TxAlmFull(c1TxAlmFull),
        .cp2af_sRx_c1(rx), .af2cp_sTx_c1(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        t_ccip_clAddr addr;
        logic         sop;
        t_ccip_clLen  len;
        logic [31:0]  tag;
    } t_exp;

    t_exp        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_seen = 0;
    int          ack_sent = 0;
    int          ack_mode = 0;
    bit          fence_first = 1'b0;
    logic [31:0] tag = 32'h100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic void expect_wr(input t_ccip_clAddr a, input logic s,
                                      input t_ccip_clLen l, input logic [31:0] t);
        t_exp e;
        e.addr = a; e.sop = s; e.len = l; e.tag = t;
        exp_q.push_back(e);
    endfunction

    // Monitor: every presented write is matched against the head of the queue
    initial begin
        t_exp e;
        forever begin
            @(negedge clk);
            if (tx.valid === 1'b1) begin
                wr_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected actual_addr=%0h required=none", tx.hdr.address);
                end else begin
                    e = exp_q.pop_front();
                    if (tx.hdr.address !== e.addr || tx.hdr.sop !== e.sop ||
                        tx.hdr.cl_len !== e.len || tx.hdr.req_type !== eREQ_WRLINE_I ||
                        tx.hdr.vc_sel !== eVC_VA || tx.data !== 512'(e.tag)) begin
                        failures++;
                        $display("FAIL wr_beat actual addr=%0h sop=%0b len=%0d type=%0d vc=%0d tag=%0h required addr=%0h sop=%0b len=%0d type=0 vc=0 tag=%0h",
                                 tx.hdr.address, tx.hdr.sop, tx.hdr.cl_len, tx.hdr.req_type,
                                 tx.hdr.vc_sel, tx.data[31:0], e.addr, e.sop, e.len, e.tag);
                    end
                end
            end
        end
    end

    // Ack responder: mode 1 unpacked per line, mode 2 packed per 4 lines
    initial begin
        rx = '0;
        forever begin
            @(posedge clk);
            #1;
            rx = '0;
            if (fence_first && wr_seen > ack_sent) begin
                rx.rspValid = 1'b1;
                rx.hdr.resp_type = eRSP_WRFENCE;
                rx.hdr.format = 1'b1;
                rx.hdr.cl_num = 2'd3;
                fence_first = 1'b0;
            end else if (ack_mode == 1 && ack_sent < wr_seen) begin
                rx.rspValid = 1'b1;
                rx.hdr.resp_type = eRSP_WRLINE;
                ack_sent++;
            end else if (ack_mode == 2 && wr_seen - ack_sent >= 4) begin
                rx.rspValid = 1'b1;
                rx.hdr.resp_type = eRSP_WRLINE;
                rx.hdr.format = 1'b1;
                rx.hdr.cl_num = 2'd3;
                ack_sent += 4;
            end
        end
    end

    task automatic feed(input int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
            if (rd_if.almostfull === 1'b0) begin
                rd_if.rvalid = 1'b1;
                rd_if.rdata  = 512'(tag);
                tag++;
                i++;
            end else begin
                rd_if.rvalid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rd_if.rvalid = 1'b0;
        if (i < n) chk("feed_timeout", 64'(i), 64'(n));
    endtask

    task automatic start_op(input logic sel, input logic [30:0] off, input logic [31:0] n);
        @(posedge clk);
        #1;
        regs[3] = {sel, off};
        regs[4] = n;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int bound);
        int i = 0;
        while (wr_seen < n && i < bound) begin
            @(posedge clk);
            i++;
        end
        if (wr_seen < n) chk("write_timeout", 64'(wr_seen), 64'(n));
    endtask

    task automatic wait_done(input string nm, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (op_done === 1'b1) seen = 1'b1;
        end
        chk({nm, "_op_done"}, 64'(seen), 64'd1);
        @(negedge clk);
        chk({nm, "_done_width"}, 64'(op_done), 64'd0);
        chk({nm, "_idle"}, 64'(op_busy), 64'd0);
        chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        logic [31:0] t0;
        bit bad;
        reset = 1'b1;
        op_start = 1'b0;
        regs = '0;
        in_addr = 42'h8000;
        out_addr = 42'h1000;
        c1TxAlmFull = 1'b0;
        rd_if.rvalid = 1'b0;
        rd_if.rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(tx.valid), 64'd0);
        chk("rst_op_done", 64'(op_done), 64'd0);
        chk("rst_op_busy", 64'(op_busy), 64'd0);
        chk("rst_almostfull", 64'(rd_if.almostfull), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single line write
        ack_mode = 1;
        t0 = tag;
        expect_wr(42'h1000, 1'b1, eCL_LEN_1, t0);
        feed(1);
        start_op(1'b0, 31'd0, 32'd1);
        wait_done("single", 100);

        // two aligned bursts with packed acks; a fence response must be ignored
        ack_mode = 2;
        fence_first = 1'b1;
        t0 = tag;
        for (int i = 0; i < 8; i++)
            expect_wr(i < 4 ? 42'h1000 : 42'h1004, (i % 4) == 0, eCL_LEN_4, t0 + 32'(i));
        feed(8);
        start_op(1'b0, 31'd0, 32'd8);
        wait_done("burst8", 200);

        // unaligned start from in_addr, unpacked acks
        ack_mode = 1;
        t0 = tag;
        expect_wr(42'h8002, 1'b1, eCL_LEN_1, t0);
        expect_wr(42'h8003, 1'b1, eCL_LEN_1, t0 + 1);
        expect_wr(42'h8004, 1'b1, eCL_LEN_4, t0 + 2);
        expect_wr(42'h8004, 1'b0, eCL_LEN_4, t0 + 3);
        expect_wr(42'h8004, 1'b0, eCL_LEN_4, t0 + 4);
        expect_wr(42'h8004, 1'b0, eCL_LEN_4, t0 + 5);
        expect_wr(42'h8008, 1'b1, eCL_LEN_1, t0 + 6);
        feed(7);
        start_op(1'b1, 31'd2, 32'd7);
        wait_done("unaligned7", 200);

        // credit limit of 4 with acks withheld
        ack_mode = 0;
        base = wr_seen;
        t0 = tag;
        for (int i = 0; i < 12; i++)
            expect_wr(42'h1000 + 42'(i / 4 * 4), (i % 4) == 0, eCL_LEN_4, t0 + 32'(i));
        feed(12);
        start_op(1'b0, 31'd0, 32'd12);
        wait_writes(base + 4, 100);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("credit_stall_beats", 64'(wr_seen - base), 64'd4);
        chk("credit_stall_busy", 64'(op_busy), 64'd1);
        ack_mode = 2;
        wait_done("credit12", 300);

        // c1TxAlmFull held mid-burst; beats resume without a new sop
        ack_mode = 1;
        base = wr_seen;
        t0 = tag;
        for (int i = 0; i < 4; i++)
            expect_wr(42'h1000, i == 0, eCL_LEN_4, t0 + 32'(i));
        feed(4);
        start_op(1'b0, 31'd0, 32'd4);
        wait_writes(base + 1, 100);
        #1;
        c1TxAlmFull = 1'b1;
        repeat (3) @(posedge clk);
        chk("almfull_hold_beats", 64'(wr_seen - base), 64'd2);
        #1;
        c1TxAlmFull = 1'b0;
        wait_done("almfull", 200);

        // zero-length operation
        base = wr_seen;
        start_op(1'b0, 31'd0, 32'd0);
        @(negedge clk);
        chk("len0_done_early", 64'(op_done), 64'd0);
        chk("len0_busy", 64'(op_busy), 64'd1);
        @(negedge clk);
        chk("len0_done_at_2", 64'(op_done), 64'd1);
        @(negedge clk);
        chk("len0_done_width", 64'(op_done), 64'd0);
        chk("len0_no_writes", 64'(wr_seen - base), 64'd0);

        // reset in RUN with three outstanding writes
        ack_mode = 0;
        base = wr_seen;
        t0 = tag;
        expect_wr(42'h1001, 1'b1, eCL_LEN_1, t0);
        expect_wr(42'h1002, 1'b1, eCL_LEN_1, t0 + 1);
        expect_wr(42'h1003, 1'b1, eCL_LEN_1, t0 + 2);
        feed(3);
        start_op(1'b0, 31'd1, 32'd5);
        wait_writes(base + 3, 100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 64'(op_busy), 64'd1);
        chk("abort_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", 64'(tx.valid), 64'd0);
        chk("abort_busy", 64'(op_busy), 64'd0);
        chk("abort_done", 64'(op_done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ack_mode = 1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (op_done !== 1'b0 || op_busy !== 1'b0) bad = 1'b1;
        end
        chk("stale_acks_ignored", 64'(bad), 64'd0);

        t0 = tag;
        expect_wr(42'h1000, 1'b1, eCL_LEN_1, t0);
        feed(1);
        start_op(1'b0, 31'd0, 32'd1);
        wait_done("after_reset", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
